// File: rtl/ad9253_lane_train_sched.sv
// Releases one AD9253 lane alignment controller at a time, with timeout/retry,
// holds trained lanes enabled and re-trains any lane that later loses lock.
`timescale 1ns/1ps
module ad9253_lane_train_sched #(
    parameter int          N_LANE      = 8,
    parameter int          LANE_W      = 3,
    parameter int          SETTLE_CYC  = 64,
    parameter logic [31:0] TIMEOUT_CYC = 32'd200_000_000,
    parameter int          MAX_RETRY   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_rdy,
    input  logic              restart,
    input  logic [N_LANE-1:0] lane_train_cpl,
    output logic [N_LANE-1:0] lane_en,
    output logic [LANE_W-1:0] cur_lane,
    output logic              busy,
    output logic              all_done,
    output logic [N_LANE-1:0] lane_ok,
    output logic [N_LANE-1:0] lane_fail,
    output logic [7:0]        relock_cnt
);

    typedef enum logic [2:0] {IDLE, SETTLE, RUN, NEXT, DONE} state_t;

    localparam logic [31:0]       SETTLE_LAST  = 32'(SETTLE_CYC - 1);
    localparam logic [31:0]       TIMEOUT_LAST = TIMEOUT_CYC - 32'd1;
    localparam logic [7:0]        RETRY_MAX    = 8'(MAX_RETRY);
    localparam logic [LANE_W-1:0] LAST_LANE    = LANE_W'(N_LANE - 1);

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   cur_lane_q, cur_lane_d;
    logic [7:0]          retry_q, retry_d;
    logic [31:0]         timer_q, timer_d;
    logic [N_LANE-1:0]   lane_ok_q, lane_ok_d;
    logic [N_LANE-1:0]   lane_fail_q, lane_fail_d;
    logic [7:0]          relock_cnt_q, relock_cnt_d;
    logic                retrain_q, retrain_d;

    logic [N_LANE-1:0]   lost_lock;
    logic                relock_hit;
    logic [LANE_W-1:0]   relock_idx;

    always_comb begin
        state_d      = state_q;
        cur_lane_d   = cur_lane_q;
        retry_d      = retry_q;
        timer_d      = timer_q;
        lane_ok_d    = lane_ok_q;
        lane_fail_d  = lane_fail_q;
        relock_cnt_d = relock_cnt_q;
        retrain_d    = retrain_q;

        // Lowest-index held lane that has lost lock wins the re-train slot.
        lost_lock  = lane_ok_q & ~lane_train_cpl;
        relock_hit = 1'b0;
        relock_idx = '0;
        for (int i = N_LANE - 1; i >= 0; i--) begin
            if (lost_lock[i]) begin
                relock_hit = 1'b1;
                relock_idx = LANE_W'(i);
            end
        end

        if (!cfg_rdy || restart) begin
            state_d     = IDLE;
            cur_lane_d  = '0;
            retry_d     = '0;
            timer_d     = '0;
            lane_ok_d   = '0;
            lane_fail_d = '0;
            retrain_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = SETTLE;
                    cur_lane_d = '0;
                    retry_d    = '0;
                    timer_d    = '0;
                end
                SETTLE: begin
                    if (timer_q == SETTLE_LAST) begin
                        state_d = RUN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                RUN: begin
                    timer_d = timer_q + 32'd1;
                    if (lane_train_cpl[cur_lane_q]) begin
                        lane_ok_d[cur_lane_q] = 1'b1;
                        state_d               = NEXT;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_d = '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 8'd1;
                            state_d = SETTLE;
                        end else begin
                            lane_fail_d[cur_lane_q] = 1'b1;
                            state_d                 = NEXT;
                        end
                    end
                end
                NEXT: begin
                    timer_d = '0;
                    if (retrain_q || cur_lane_q == LAST_LANE) begin
                        state_d   = DONE;
                        retrain_d = 1'b0;
                    end else begin
                        cur_lane_d = cur_lane_q + LANE_W'(1);
                        retry_d    = '0;
                        state_d    = SETTLE;
                    end
                end
                DONE: begin
                    if (relock_hit) begin
                        lane_ok_d[relock_idx] = 1'b0;
                        cur_lane_d            = relock_idx;
                        retry_d               = '0;
                        timer_d               = '0;
                        retrain_d             = 1'b1;
                        state_d               = SETTLE;
                        if (relock_cnt_q != 8'hFF) begin
                            relock_cnt_d = relock_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_lane_q   <= '0;
            retry_q      <= '0;
            timer_q      <= '0;
            lane_ok_q    <= '0;
            lane_fail_q  <= '0;
            relock_cnt_q <= '0;
            retrain_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_lane_q   <= cur_lane_d;
            retry_q      <= retry_d;
            timer_q      <= timer_d;
            lane_ok_q    <= lane_ok_d;
            lane_fail_q  <= lane_fail_d;
            relock_cnt_q <= relock_cnt_d;
            retrain_q    <= retrain_d;
        end
    end

    // Enables decode flops only, so no input can glitch a lane controller.
    generate
        for (genvar gi = 0; gi < N_LANE; gi++) begin : g_lane_en
            assign lane_en[gi] = lane_ok_q[gi] |
                                 ((state_q == RUN) && (cur_lane_q == LANE_W'(gi)));
        end
    endgenerate

    assign cur_lane   = cur_lane_q;
    assign busy       = (state_q == SETTLE) || (state_q == RUN) || (state_q == NEXT);
    assign all_done   = (state_q == DONE);
    assign lane_ok    = lane_ok_q;
    assign lane_fail  = lane_fail_q;
    assign relock_cnt = relock_cnt_q;

endmodule

// File: tb/tb_ad9253_lane_train_sched.sv
// Scoreboarded bench: lane controllers are emulated, expected edge events on
// lane_en/lane_ok/lane_fail/all_done/relock_cnt come from a timing model.
`timescale 1ns/1ps
module tb_ad9253_lane_train_sched;

    localparam int N     = 4;
    localparam int LW    = 2;
    localparam int SC    = 8;
    localparam int TO    = 100;
    localparam int MR    = 2;
    localparam int NATT  = 8;
    localparam int NEVER = 100000;

    localparam int K_DN = 0, K_UP = 1, K_OK = 2, K_FAIL = 3, K_DONE = 4, K_RELOCK = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_rdy = 1'b0;
    logic          restart = 1'b0;
    logic [N-1:0]  lane_train_cpl = '0;
    logic [N-1:0]  lane_en, lane_ok, lane_fail;
    logic [LW-1:0] cur_lane;
    logic          busy, all_done;
    logic [7:0]    relock_cnt;

    ad9253_lane_train_sched #(
        .N_LANE(N), .LANE_W(LW), .SETTLE_CYC(SC), .TIMEOUT_CYC(32'(TO)), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst), .cfg_rdy(cfg_rdy), .restart(restart),
        .lane_train_cpl(lane_train_cpl), .lane_en(lane_en), .cur_lane(cur_lane),
        .busy(busy), .all_done(all_done), .lane_ok(lane_ok), .lane_fail(lane_fail),
        .relock_cnt(relock_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int lane;
        int t;
    } ev_t;

    ev_t exp_q[$];
    ev_t hist[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // Per-lane, per-attempt completion delay (cycles after lane_en rises).
    int dly[N][NATT];
    int epoch = 0;
    int drop_seq = 0;
    int drop_lane = 0;

    int           first_run[N];
    logic [N-1:0] m_ok, m_fail;

    function automatic string kname(input int k);
        case (k)
            K_DN:     return "en_fall";
            K_UP:     return "en_rise";
            K_OK:     return "ok_set";
            K_FAIL:   return "fail_set";
            K_DONE:   return "done_rise";
            default:  return "relock";
        endcase
    endfunction

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic int ev_key(input ev_t e);
        return e.t * 64 + e.kind * 8 + e.lane;
    endfunction

    function automatic void push_ev(input int k, input int l, input int t);
        ev_t e;
        int  pos;
        e.kind = k;
        e.lane = l;
        e.t    = t;
        pos = exp_q.size();
        while (pos > 0 && ev_key(exp_q[pos-1]) > ev_key(e)) pos--;
        exp_q.insert(pos, e);
        hist.push_back(e);
    endfunction

    // Abort at edge a: predicted events from a onwards vanish, lanes up drop.
    function automatic void cut(input int a);
        bit  up[N];
        ev_t keep[$];
        for (int l = 0; l < N; l++) up[l] = 1'b0;
        foreach (hist[i]) begin
            if (hist[i].t < a) begin
                if (hist[i].kind == K_UP) up[hist[i].lane] = 1'b1;
                if (hist[i].kind == K_DN) up[hist[i].lane] = 1'b0;
            end
        end
        foreach (exp_q[i]) if (exp_q[i].t < a) keep.push_back(exp_q[i]);
        exp_q = keep;
        hist.delete();
        for (int l = 0; l < N; l++) if (up[l]) push_ev(K_DN, l, a);
    endfunction

    // SETTLE entered at edge t0; lanes first..last trained; returns DONE edge.
    function automatic int model_seq(input int t0, input int first, input int last,
                                     input int att_off);
        int t = t0;
        for (int l = first; l <= last; l++) begin
            int n = 0;
            for (int a = 0; a <= MR; a++) begin
                int r = t + SC;
                int d = dly[l][a + att_off];
                if (a == 0) first_run[l] = r;
                push_ev(K_UP, l, r);
                if (d < TO) begin
                    push_ev(K_OK, l, r + d + 1);
                    m_ok[l] = 1'b1;
                    n = r + d + 1;
                    break;
                end
                push_ev(K_DN, l, r + TO);
                if (a < MR) begin
                    t = r + TO;
                end else begin
                    push_ev(K_FAIL, l, r + TO);
                    m_fail[l] = 1'b1;
                    n = r + TO;
                end
            end
            t = n + 1;
        end
        push_ev(K_DONE, 0, t);
        return t;
    endfunction

    function automatic void fill_dly(input int mode);
        for (int l = 0; l < N; l++) begin
            for (int a = 0; a < NATT; a++) begin
                if (mode == 0)      dly[l][a] = 20;
                else if (mode == 1) dly[l][a] = int'($urandom_range(0, TO - 1));
                else if ($urandom_range(0, 4) == 0) dly[l][a] = NEVER;
                else                dly[l][a] = int'($urandom_range(0, TO + 20));
            end
        end
    endfunction

    function automatic void observe(input int k, input int l);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got %s lane %0d at cycle %0d, expected no event",
                     kname(k), l, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.lane != l || e.t != cyc) begin
                errors++;
                $display("FAIL event: got %s lane %0d at cycle %0d, expected %s lane %0d at cycle %0d",
                         kname(k), l, cyc, kname(e.kind), e.lane, e.t);
            end else begin
                $display("event %s lane %0d cycle %0d ok", kname(k), l, cyc);
            end
        end
    endfunction

    // Monitor + lane controller emulation, both sampled 1 ns after each edge.
    initial begin : mon
        logic [N-1:0] p_en, p_ok, p_fail;
        logic         p_done;
        logic [7:0]   p_rel;
        int           age[N];
        int           att[N];
        bit           drop[N];
        int           seen_epoch, seen_drop, d;
        p_en = '0; p_ok = '0; p_fail = '0; p_done = 1'b0; p_rel = '0;
        seen_epoch = 0; seen_drop = 0;
        for (int i = 0; i < N; i++) begin
            age[i] = 0; att[i] = 0; drop[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mon_en) begin
                for (int l = 0; l < N; l++) if (p_en[l] && !lane_en[l]) observe(K_DN, l);
                for (int l = 0; l < N; l++) if (!p_en[l] && lane_en[l]) observe(K_UP, l);
                for (int l = 0; l < N; l++) if (!p_ok[l] && lane_ok[l]) observe(K_OK, l);
                for (int l = 0; l < N; l++) if (!p_fail[l] && lane_fail[l]) observe(K_FAIL, l);
                if (!p_done && all_done) observe(K_DONE, 0);
                if (p_rel != relock_cnt) observe(K_RELOCK, 0);
            end
            if (epoch != seen_epoch) begin
                seen_epoch = epoch;
                for (int i = 0; i < N; i++) begin
                    age[i] = 0; att[i] = 0; drop[i] = 1'b0;
                end
            end
            if (drop_seq != seen_drop) begin
                seen_drop       = drop_seq;
                drop[drop_lane] = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (lane_en[i]) begin
                    age[i] = p_en[i] ? age[i] + 1 : 0;
                end else begin
                    if (p_en[i]) begin
                        att[i]++;
                        drop[i] = 1'b0;
                    end
                    age[i] = 0;
                end
                d = (att[i] < NATT) ? dly[i][att[i]] : NEVER;
                lane_train_cpl[i] = lane_en[i] && (age[i] >= d) && !drop[i];
            end
            p_en = lane_en; p_ok = lane_ok; p_fail = lane_fail;
            p_done = all_done; p_rel = relock_cnt;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic check_zero(input string tag, input int rel);
        chk({tag, " lane_en"}, int'(lane_en), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " all_done"}, int'(all_done), 0);
        chk({tag, " lane_ok"}, int'(lane_ok), 0);
        chk({tag, " lane_fail"}, int'(lane_fail), 0);
        chk({tag, " cur_lane"}, int'(cur_lane), 0);
        chk({tag, " relock_cnt"}, int'(relock_cnt), rel);
    endtask

    task automatic check_done(input string tag, input logic [N-1:0] ok, input logic [N-1:0] fl);
        chk({tag, " all_done"}, int'(all_done), 1);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " lane_ok"}, int'(lane_ok), int'(ok));
        chk({tag, " lane_fail"}, int'(lane_fail), int'(fl));
        chk({tag, " lane_en"}, int'(lane_en), int'(ok));
        chk({tag, " pending events"}, exp_q.size(), 0);
    endtask

    task automatic pulse_restart(output int s);
        restart = 1'b1;
        cut(cyc + 1);
        tick(1);
        restart = 1'b0;
        s = cyc + 1;
    endtask

    initial begin : stim
        int done_t, s, x;
        for (int l = 0; l < N; l++)
            for (int a = 0; a < NATT; a++) dly[l][a] = NEVER;

        // Reset state, then idle with cfg_rdy low.
        tick(2);
        check_zero("reset", 0);
        rst = 1'b0;
        tick(2);
        check_zero("idle", 0);
        mon_en = 1'b1;

        // All lanes complete 20 cycles after enable.
        fill_dly(0);
        epoch++;
        m_ok = '0; m_fail = '0;
        cfg_rdy = 1'b1;
        done_t = model_seq(cyc + 1, 0, N - 1, 0);
        wait_until(done_t + 2);
        check_done("all_pass", 4'b1111, 4'b0000);

        // Lane 3 loses lock in DONE.
        dly[3][1] = int'($urandom_range(1, 60));
        drop_lane = 3;
        drop_seq++;
        x = cyc + 2;
        push_ev(K_DN, 3, x);
        push_ev(K_RELOCK, 0, x);
        m_ok[3] = 1'b0;
        done_t = model_seq(x, 3, 3, 1);
        wait_until(x);
        chk("relock cur_lane", int'(cur_lane), 3);
        chk("relock lane_ok", int'(lane_ok), 4'b0111);
        chk("relock relock_cnt", int'(relock_cnt), 1);
        chk("relock busy", int'(busy), 1);
        wait_until(done_t + 2);
        check_done("relock", 4'b1111, 4'b0000);

        // Restart; lane 2 never completes.
        pulse_restart(s);
        check_zero("restart", 1);
        fill_dly(1);
        for (int a = 0; a < NATT; a++) dly[2][a] = NEVER;
        epoch++;
        m_ok = '0; m_fail = '0;
        done_t = model_seq(s, 0, N - 1, 0);
        wait_until(done_t + 2);
        check_done("lane2_fail", 4'b1011, 4'b0100);

        // Completion on the timeout cycle of lane 1.
        pulse_restart(s);
        fill_dly(1);
        dly[1][0] = TO - 1;
        epoch++;
        m_ok = '0; m_fail = '0;
        done_t = model_seq(s, 0, N - 1, 0);
        wait_until(done_t + 2);
        check_done("same_cycle", 4'b1111, 4'b0000);

        // cfg_rdy falls mid-RUN on lane 1, then training restarts.
        pulse_restart(s);
        fill_dly(2);
        dly[1][0] = NEVER;
        epoch++;
        m_ok = '0; m_fail = '0;
        done_t = model_seq(s, 0, N - 1, 0);
        wait_until(first_run[1] + 5);
        cfg_rdy = 1'b0;
        cut(cyc + 1);
        tick(1);
        check_zero("cfg_abort", 1);
        tick(3);
        fill_dly(2);
        epoch++;
        m_ok = '0; m_fail = '0;
        cfg_rdy = 1'b1;
        done_t = model_seq(cyc + 1, 0, N - 1, 0);
        wait_until(done_t + 2);
        check_done("after_abort", m_ok, m_fail);

        // Asynchronous rst in the middle of SETTLE.
        pulse_restart(s);
        fill_dly(2);
        epoch++;
        m_ok = '0; m_fail = '0;
        done_t = model_seq(s, 0, N - 1, 0);
        tick(3);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check_zero("async_rst", 0);
        exp_q.delete();
        hist.delete();
        tick(2);
        rst = 1'b0;
        fill_dly(2);
        epoch++;
        m_ok = '0; m_fail = '0;
        mon_en = 1'b1;
        done_t = model_seq(cyc + 1, 0, N - 1, 0);
        wait_until(done_t + 2);
        check_done("after_rst", m_ok, m_fail);
        chk("after_rst relock_cnt", int'(relock_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ad9253_lane_train_sched.md
# ad9253_lane_train_sched

Sequences link training across the ADC data lanes of the 32-channel AD9253 front end. Each lane has its own alignment controller, and those controllers load the board power rail and delay tuning when they run together. This block releases one lane controller at a time through that controller's cfg_rdy input and waits for its training-complete flag. It retries on timeout, holds trained lanes enabled, and re-trains any lane that later loses lock.

## Interface
- N_LANE, 8, number of lane alignment controllers scheduled
- LANE_W, 3, width of lane index; must satisfy 2^LANE_W >= N_LANE
- SETTLE_CYC, 64, cycles a lane is held disabled before each (re)start; must be >= 1
- TIMEOUT_CYC, 32'd200_000_000, maximum RUN cycles per attempt; must be >= 1
- MAX_RETRY, 3, extra attempts after the first timeout before a lane is declared failed
- clk  in  1  system clock for this block and all lane controllers
- rst  in  1  asynchronous, active-high reset
- cfg_rdy  in  1  ADC SPI configuration complete; low aborts all training
- restart  in  1  single-cycle pulse; restarts the full sequence from lane 0
- lane_train_cpl  in  N_LANE  per-lane training-complete level from the lane controllers
- lane_en  out  N_LANE  per-lane enable, driven into each lane controller's cfg_rdy
- cur_lane  out  LANE_W  lane currently being trained
- busy  out  1  high in SETTLE, RUN and NEXT
- all_done  out  1  high in DONE
- lane_ok  out  N_LANE  lanes trained and held
- lane_fail  out  N_LANE  lanes that exhausted their retries
- relock_cnt  out  8  count of lock-loss re-trains, saturates at 255

## Operation
- States: IDLE, SETTLE, RUN, NEXT, DONE. All registers reset to 0 and the state resets to IDLE.
- lane_en = lane_ok | (state==RUN ? onehot(cur_lane) : 0). It decodes registered state only and has no combinational path from any input.
- Global abort has top priority. If cfg_rdy is low or restart is high, the next state is IDLE, and cur_lane, retry, timer, lane_ok and lane_fail are all cleared. relock_cnt is not cleared.
- IDLE: when cfg_rdy is high and restart is low, go to SETTLE with cur_lane=0 and retry=0.
- SETTLE: timer counts 0..SETTLE_CYC-1. At the last count, go to RUN and clear the timer.
- RUN: timer increments each cycle.
  - If lane_train_cpl[cur_lane] is high, set lane_ok[cur_lane] and go to NEXT.
  - Otherwise, when timer==TIMEOUT_CYC-1 and retry<MAX_RETRY: increment retry, go to SETTLE. The lane drops for SETTLE_CYC cycles, which resets its controller.
  - Otherwise, when timer==TIMEOUT_CYC-1 and retry==MAX_RETRY: set lane_fail[cur_lane] and go to NEXT.
  - If completion and timeout occur in the same cycle, completion wins.
- NEXT: if cur_lane==N_LANE-1, go to DONE. Otherwise increment cur_lane, clear retry, and go to SETTLE.
- DONE: all_done=1.
  - Watch every lane whose lane_ok bit is set. If its lane_train_cpl drops, take the lowest such index i:
    - clear lane_ok[i]
    - set cur_lane=i and clear retry
    - increment relock_cnt (saturating)
    - go to SETTLE
  - After the re-train resolves, NEXT returns directly to DONE regardless of index, because a re-train flag is set for this case.
- Failed lanes stay disabled and are never retried until the next restart, cfg_rdy low, or rst.
- During RUN and SETTLE, a lane already in lane_ok that drops cpl is ignored until DONE. In DONE it is handled by the relock path.

## Timing
- If cfg_rdy is sampled high at edge 0, SETTLE is entered at edge 1 and RUN at edge 1+SETTLE_CYC. lane_en[0] rises at that same edge.
- A completion sampled in RUN at edge t gives lane_ok at t+1 and NEXT at t+1. If more lanes remain, SETTLE is entered at t+2.
- One attempt that times out occupies exactly TIMEOUT_CYC RUN cycles.
- A lane with no completion occupies (MAX_RETRY+1)*(SETTLE_CYC+TIMEOUT_CYC) cycles, plus 1 cycle in NEXT.
- Abort: cfg_rdy low at edge t gives lane_en=0, busy=0 and all_done=0 at t+1.
- rst assertion immediately forces every output to 0, without waiting for a clock edge.

## Test plan
Parameters: N_LANE=4, SETTLE_CYC=8, TIMEOUT_CYC=100, MAX_RETRY=2.
- All lanes pass: each lane_train_cpl rises 20 cycles after its lane_en bit rises. Required:
  - lane_en progresses 0001 → 0011 → 0111 → 1111
  - all_done=1 with lane_ok=1111 and lane_fail=0000
- Lane 2 never completes. Required:
  - lane_en[2] pulses 3 times, each for 100 cycles, separated by 8 low cycles
  - then lane_fail=0100 and lane_ok=1011
  - all_done=1, lane_en=1011
- Completion on the same cycle as the timeout (timer==99) on lane 1: lane_ok[1]=1, lane_fail[1]=0, no retry.
- In DONE, lane_train_cpl[3] drops. Required:
  - lane_ok[3] clears and cur_lane=3
  - relock_cnt=1
  - lane 3 re-trains after 8 cycles, then all_done returns with lanes 0-2 held enabled throughout
- cfg_rdy falls mid-RUN on lane 1. Required: next cycle state is IDLE and all outputs are 0 except relock_cnt. When cfg_rdy rises again, training restarts from lane 0.
- rst asserted asynchronously mid-SETTLE: all outputs are 0 before the next clk edge and relock_cnt is 0. After rst is released with cfg_rdy high, the full sequence runs from lane 0.
